// File: rtl/gsensor_spi3_responder.sv
// -----------------------------------------------------------------------------
// gsensor_spi3_responder
//
// Peripheral end of the 3-wire SPI accelerometer link. It emulates the sensor's
// register map and answers register reads and writes from the SPI master. XYZ
// samples come from a fabric-side source, and the block raises an interrupt
// when new data arrives.
//
// Frame: a command byte sent MSB first {R/W, MB, addr[5:0]}, then any number
//        of data bytes. SPI mode 3 is used, so SCLK idles high. The responder
//        samples SDAT on SCLK rise and drives SDAT on SCLK fall.
//
// Ports
//   clk_clk       system clock, at least 8x the SCLK frequency
//   reset_reset   asynchronous active-high reset
//   spi_sclk      SPI clock from the master
//   spi_cs_n      chip select, active low
//   spi_sdat_in   SDAT pad input
//   spi_sdat_out  SDAT value to drive (the top level builds the tristate)
//   spi_sdat_oe   SDAT output enable
//   g_sensor_int  DATA_READY interrupt, active high, registered
//   sample_valid  one-cycle strobe that marks a new XYZ sample
//   sample_x/y/z  16-bit two's-complement sample values
// -----------------------------------------------------------------------------
module gsensor_spi3_responder #(
  parameter logic [7:0]  DEVID       = 8'hE5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdat_in,
  output logic        spi_sdat_out,
  output logic        spi_sdat_oe,
  output logic        g_sensor_int,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z
);

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATA_FIRST  = 6'h32;
  localparam logic [5:0] ADDR_DATA_LAST   = 6'h37;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q,   cs_prev_d;

  logic sclk_s, cs_s, sdat_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sdat_s = sdat_sync_q[SYNC_STAGES-1];

  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;
  assign cs_rise   =  cs_s   & ~cs_prev_q;
  assign cs_fall   = ~cs_s   &  cs_prev_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
    sdat_sync_d = {sdat_sync_q[SYNC_STAGES-2:0], spi_sdat_in};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  // ---------------------------------------------------------------------------
  // Protocol and register state
  // ---------------------------------------------------------------------------
  state_t      state_q,       state_d;
  logic [2:0]  bit_cnt_q,     bit_cnt_d;
  logic [7:0]  shift_q,       shift_d;
  logic [5:0]  addr_q,        addr_d;
  logic        mb_q,          mb_d;
  logic        wr_en_q,       wr_en_d;
  logic [7:0]  wr_data_q,     wr_data_d;
  logic        sdat_out_q,    sdat_out_d;
  logic        sdat_oe_q,     sdat_oe_d;
  logic        int_q,         int_d;

  logic [7:0]  bw_rate_q,     bw_rate_d;
  logic [7:0]  power_ctl_q,   power_ctl_d;
  logic        int_en_q,      int_en_d;     // INT_ENABLE[7] only
  logic [7:0]  data_format_q, data_format_d;
  logic [47:0] data_q,        data_d;       // 0x32..0x37, byte 0 at [7:0]
  logic        data_ready_q,  data_ready_d;
  logic        pend_q,        pend_d;
  logic [47:0] pend_data_q,   pend_data_d;

  logic [7:0]  rd_byte;
  logic [47:0] sample_word;
  logic        set_ready;
  logic        clr_ready;

  // Little-endian packing, so DATAX0 = sample_x[7:0] sits at address 0x32.
  assign sample_word = {sample_z, sample_y, sample_x};

  // Register read mux, addressed by the current frame address.
  always_comb begin
    rd_byte = 8'h00;
    case (addr_q)
      ADDR_DEVID:       rd_byte = DEVID;
      ADDR_BW_RATE:     rd_byte = bw_rate_q;
      ADDR_POWER_CTL:   rd_byte = power_ctl_q;
      ADDR_INT_ENABLE:  rd_byte = {int_en_q, 7'b0};
      ADDR_INT_SOURCE:  rd_byte = {data_ready_q, 7'b0};
      ADDR_DATA_FORMAT: rd_byte = data_format_q;
      6'h32:            rd_byte = data_q[7:0];
      6'h33:            rd_byte = data_q[15:8];
      6'h34:            rd_byte = data_q[23:16];
      6'h35:            rd_byte = data_q[31:24];
      6'h36:            rd_byte = data_q[39:32];
      6'h37:            rd_byte = data_q[47:40];
      default:          rd_byte = 8'h00;
    endcase
  end

  // NOTE: every signal written here is first given a default value. Without
  // one, a path that skips an assignment would infer a latch.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    addr_d        = addr_q;
    mb_d          = mb_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    sdat_out_d    = sdat_out_q;
    sdat_oe_d     = sdat_oe_q;
    bw_rate_d     = bw_rate_q;
    power_ctl_d   = power_ctl_q;
    int_en_d      = int_en_q;
    data_format_d = data_format_q;
    data_d        = data_q;
    pend_d        = pend_q;
    pend_data_d   = pend_data_q;
    set_ready     = 1'b0;
    clr_ready     = 1'b0;

    // A byte completed on the previous cycle is committed now. The address
    // steps even when the target is read-only or unmapped.
    if (wr_en_q) begin
      case (addr_q)
        ADDR_BW_RATE:     bw_rate_d     = wr_data_q;
        ADDR_POWER_CTL:   power_ctl_d   = wr_data_q;
        ADDR_INT_ENABLE:  int_en_d      = wr_data_q[7];
        ADDR_DATA_FORMAT: data_format_d = wr_data_q;
        default:          ;
      endcase
      if (mb_q) addr_d = addr_q + 6'd1;
    end

    if (cs_rise) begin
      // End of frame, or an abort. A partial byte is dropped because only a
      // full byte ever raises wr_en.
      state_d    = ST_IDLE;
      sdat_oe_d  = 1'b0;
      sdat_out_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
          end
        end

        ST_CMD: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[6:0], sdat_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              mb_d    = shift_d[6];
              addr_d  = shift_d[5:0];
              state_d = shift_d[7] ? ST_RDATA : ST_WDATA;
            end
          end
        end

        ST_WDATA: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[6:0], sdat_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_en_d   = 1'b1;
              wr_data_d = shift_d;
            end
          end
        end

        ST_RDATA: begin
          if (sclk_fall) begin
            sdat_oe_d = 1'b1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd0) begin
              // Byte boundary: fetch the register, present its MSB, and step
              // the address for the next byte.
              sdat_out_d = rd_byte[7];
              shift_d    = {rd_byte[6:0], 1'b0};
              clr_ready  = (addr_q >= ADDR_DATA_FIRST) && (addr_q <= ADDR_DATA_LAST);
              if (mb_q) addr_d = addr_q + 6'd1;
            end else begin
              sdat_out_d = shift_q[7];
              shift_d    = {shift_q[6:0], 1'b0};
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // Sample capture. While a frame is open the sample is parked so that a
    // multi-byte read sees one coherent sample. A strobe on the same cycle as
    // the CS_N rise is newer than the parked sample and overrides it.
    if (cs_rise && pend_q) begin
      data_d    = pend_data_q;
      pend_d    = 1'b0;
      set_ready = 1'b1;
    end
    if (sample_valid && power_ctl_q[3]) begin
      if (cs_s) begin
        data_d    = sample_word;
        set_ready = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = sample_word;
      end
    end

    // When a set and a clear land on the same cycle, the set wins.
    if (set_ready)      data_ready_d = 1'b1;
    else if (clr_ready) data_ready_d = 1'b0;
    else                data_ready_d = data_ready_q;

    int_d = data_ready_q & int_en_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the clock edge.
  // NOTE: the sample registers are plain flops, not a memory array, so they
  // are reset along with the rest of the state.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_sync_q   <= '1;
      cs_sync_q     <= '1;
      sdat_sync_q   <= '0;
      sclk_prev_q   <= 1'b1;
      cs_prev_q     <= 1'b1;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      addr_q        <= 6'h00;
      mb_q          <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= 8'h00;
      sdat_out_q    <= 1'b0;
      sdat_oe_q     <= 1'b0;
      int_q         <= 1'b0;
      bw_rate_q     <= 8'h0A;
      power_ctl_q   <= 8'h00;
      int_en_q      <= 1'b0;
      data_format_q <= 8'h00;
      data_q        <= 48'h0;
      data_ready_q  <= 1'b0;
      pend_q        <= 1'b0;
      pend_data_q   <= 48'h0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      sdat_sync_q   <= sdat_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      addr_q        <= addr_d;
      mb_q          <= mb_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      sdat_out_q    <= sdat_out_d;
      sdat_oe_q     <= sdat_oe_d;
      int_q         <= int_d;
      bw_rate_q     <= bw_rate_d;
      power_ctl_q   <= power_ctl_d;
      int_en_q      <= int_en_d;
      data_format_q <= data_format_d;
      data_q        <= data_d;
      data_ready_q  <= data_ready_d;
      pend_q        <= pend_d;
      pend_data_q   <= pend_data_d;
    end
  end

  assign spi_sdat_out = sdat_out_q;
  assign spi_sdat_oe  = sdat_oe_q;
  assign g_sensor_int = int_q;

endmodule

// File: tb/tb_gsensor_spi3_responder.sv
// -----------------------------------------------------------------------------
// tb_gsensor_spi3_responder
//
// Directed bench for the 3-wire SPI G-sensor responder. It plays the SPI
// master in mode 3 with an SCLK half-period of 8 system clocks. Expected bytes
// are worked out by hand from the register map.
// -----------------------------------------------------------------------------
module tb_gsensor_spi3_responder;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_sdat_in;
  logic        spi_sdat_out;
  logic        spi_sdat_oe;
  logic        g_sensor_int;
  logic        sample_valid;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic [15:0] sample_z;

  always #5 clk = ~clk;

  gsensor_spi3_responder #(
    .DEVID       (8'hE5),
    .SYNC_STAGES (2)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (reset_reset),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_sdat_in  (spi_sdat_in),
    .spi_sdat_out (spi_sdat_out),
    .spi_sdat_oe  (spi_sdat_oe),
    .g_sensor_int (g_sensor_int),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z)
  );

  int          n_checks = 0;
  int          n_pass   = 0;

  logic [7:0]  tx_buf [8];
  logic [7:0]  rx_buf [8];
  logic        oe_in_cmd;
  logic        oe_last;
  logic        oe_after_rise;
  logic        int_after_b0;
  int          strobe_byte;
  logic [15:0] sx, sy, sz;
  logic        rb, ob;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic half_bit();
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x     = x;
    sample_y     = y;
    sample_z     = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // One SCLK period: fall and drive the bit, sample MISO just before the rise.
  task automatic send_bit(input logic b, output logic rx, output logic oe);
    spi_sclk    = 1'b0;
    spi_sdat_in = b;
    half_bit();
    rx          = spi_sdat_out;
    oe          = spi_sdat_oe;
    spi_sclk    = 1'b1;
    half_bit();
  endtask

  // Command byte, then nbytes full data bytes, then abort_bits bits of one
  // more byte (taken from tx_buf[nbytes]), then CS_N rise.
  task automatic do_frame(input logic [7:0] cmd, input int nbytes, input int abort_bits);
    logic       r, o;
    logic [7:0] b;
    b            = 8'h00;
    oe_in_cmd    = 1'b0;
    oe_last      = 1'b0;
    int_after_b0 = 1'b0;
    spi_cs_n     = 1'b0;
    half_bit();
    for (int i = 7; i >= 0; i--) begin
      send_bit(cmd[i], r, o);
      oe_in_cmd = oe_in_cmd | o;
    end
    for (int n = 0; n < nbytes; n++) begin
      if (n == strobe_byte) pulse_sample(sx, sy, sz);
      for (int i = 7; i >= 0; i--) begin
        send_bit(tx_buf[n][i], r, o);
        b[i]    = r;
        oe_last = o;
      end
      rx_buf[n] = b;
      if (n == 0) int_after_b0 = g_sensor_int;
    end
    for (int i = 7; i >= 8 - abort_bits; i--) begin
      send_bit(tx_buf[nbytes][i], r, o);
      oe_last = o;
    end
    spi_cs_n    = 1'b1;
    spi_sdat_in = 1'b0;
    repeat (3) @(negedge clk);
    oe_after_rise = spi_sdat_oe;
    half_bit();
  endtask

  initial begin
    reset_reset  = 1'b1;
    spi_sclk     = 1'b1;
    spi_cs_n     = 1'b1;
    spi_sdat_in  = 1'b0;
    sample_valid = 1'b0;
    sample_x     = 16'h0;
    sample_y     = 16'h0;
    sample_z     = 16'h0;
    strobe_byte  = -1;
    sx = 16'h0; sy = 16'h0; sz = 16'h0;
    for (int i = 0; i < 8; i++) begin
      tx_buf[i] = 8'h00;
      rx_buf[i] = 8'h00;
    end

    repeat (4) @(negedge clk);
    check("rst_oe",  {31'b0, spi_sdat_oe},  32'h0);
    check("rst_out", {31'b0, spi_sdat_out}, 32'h0);
    check("rst_int", {31'b0, g_sensor_int}, 32'h0);
    reset_reset = 1'b0;
    repeat (4) @(negedge clk);

    // DEVID read; oe only during the data phase.
    do_frame(8'h80, 1, 0);
    check("devid",        {24'b0, rx_buf[0]},    32'hE5);
    check("oe_cmd_phase", {31'b0, oe_in_cmd},     32'h0);
    check("oe_data",      {31'b0, oe_last},       32'h1);
    check("oe_after_cs",  {31'b0, oe_after_rise}, 32'h0);

    // Strobe while MEASURE=0 is ignored.
    pulse_sample(16'hAAAA, 16'hBBBB, 16'hCCCC);
    repeat (4) @(negedge clk);
    do_frame(8'hB0, 1, 0);
    check("int_src_nomeas", {24'b0, rx_buf[0]}, 32'h00);
    do_frame(8'hB2, 1, 0);
    check("datax0_nomeas",  {24'b0, rx_buf[0]}, 32'h00);

    // Default BW_RATE.
    do_frame(8'hAC, 1, 0);
    check("bw_rate_dflt", {24'b0, rx_buf[0]}, 32'h0A);

    // POWER_CTL write/read; DEVID is read-only.
    tx_buf[0] = 8'h08;
    do_frame(8'h2D, 1, 0);
    do_frame(8'hAD, 1, 0);
    check("power_ctl", {24'b0, rx_buf[0]}, 32'h08);
    tx_buf[0] = 8'h55;
    do_frame(8'h00, 1, 0);
    do_frame(8'h80, 1, 0);
    check("devid_ro", {24'b0, rx_buf[0]}, 32'hE5);

    // INT_ENABLE keeps only bit 7.
    tx_buf[0] = 8'hFF;
    do_frame(8'h2E, 1, 0);
    do_frame(8'hAE, 1, 0);
    check("int_enable", {24'b0, rx_buf[0]}, 32'h80);

    // Sample with CS_N high: interrupt rises.
    pulse_sample(16'h1234, 16'hFFFE, 16'h0100);
    repeat (4) @(negedge clk);
    check("int_set", {31'b0, g_sensor_int}, 32'h1);

    // Multi-byte XYZ read; DATA_READY clears on the first data byte.
    do_frame(8'hF2, 6, 0);
    check("x0", {24'b0, rx_buf[0]}, 32'h34);
    check("x1", {24'b0, rx_buf[1]}, 32'h12);
    check("y0", {24'b0, rx_buf[2]}, 32'hFE);
    check("y1", {24'b0, rx_buf[3]}, 32'hFF);
    check("z0", {24'b0, rx_buf[4]}, 32'h00);
    check("z1", {24'b0, rx_buf[5]}, 32'h01);
    check("int_clr_b0",  {31'b0, int_after_b0}, 32'h0);
    check("int_clr_end", {31'b0, g_sensor_int}, 32'h0);

    // New sample mid-frame: the frame stays coherent; applied on CS_N rise.
    sx = 16'h5678; sy = 16'h8000; sz = 16'h7FFF;
    strobe_byte = 3;
    do_frame(8'hF2, 6, 0);
    strobe_byte = -1;
    check("coh_x0", {24'b0, rx_buf[0]}, 32'h34);
    check("coh_x1", {24'b0, rx_buf[1]}, 32'h12);
    check("coh_y0", {24'b0, rx_buf[2]}, 32'hFE);
    check("coh_y1", {24'b0, rx_buf[3]}, 32'hFF);
    check("coh_z0", {24'b0, rx_buf[4]}, 32'h00);
    check("coh_z1", {24'b0, rx_buf[5]}, 32'h01);
    check("int_pend_apply", {31'b0, g_sensor_int}, 32'h1);
    do_frame(8'hF2, 6, 0);
    check("new_x0", {24'b0, rx_buf[0]}, 32'h78);
    check("new_x1", {24'b0, rx_buf[1]}, 32'h56);
    check("new_y0", {24'b0, rx_buf[2]}, 32'h00);
    check("new_y1", {24'b0, rx_buf[3]}, 32'h80);
    check("new_z0", {24'b0, rx_buf[4]}, 32'hFF);
    check("new_z1", {24'b0, rx_buf[5]}, 32'h7F);

    // Address wrap 0x3F -> 0x00.
    do_frame(8'hFE, 3, 0);
    check("wrap_3e", {24'b0, rx_buf[0]}, 32'h00);
    check("wrap_3f", {24'b0, rx_buf[1]}, 32'h00);
    check("wrap_00", {24'b0, rx_buf[2]}, 32'hE5);

    // MB=0 holds the address.
    do_frame(8'hAD, 2, 0);
    check("hold_b0", {24'b0, rx_buf[0]}, 32'h08);
    check("hold_b1", {24'b0, rx_buf[1]}, 32'h08);

    // Aborted write after 4 bits leaves BW_RATE alone.
    tx_buf[0] = 8'h33;
    do_frame(8'h2C, 0, 4);
    do_frame(8'hAC, 1, 0);
    check("abort_wr", {24'b0, rx_buf[0]}, 32'h0A);

    // Aborted read: oe drops within SYNC_STAGES+1 clocks of CS_N rise.
    do_frame(8'h80, 0, 4);
    check("abort_rd_oe_up",   {31'b0, oe_last},       32'h1);
    check("abort_rd_oe_down", {31'b0, oe_after_rise}, 32'h0);

    // MB write through the read-only INT_SOURCE still steps to DATA_FORMAT.
    tx_buf[0] = 8'hFF;
    tx_buf[1] = 8'h01;
    do_frame(8'h70, 2, 0);
    do_frame(8'hB0, 1, 0);
    check("int_src_ro",  {24'b0, rx_buf[0]}, 32'h00);
    do_frame(8'hB1, 1, 0);
    check("data_format", {24'b0, rx_buf[0]}, 32'h01);

    // MB write of two RW registers.
    tx_buf[0] = 8'h0F;
    tx_buf[1] = 8'h08;
    do_frame(8'h6C, 2, 0);
    do_frame(8'hEC, 2, 0);
    check("mbw_bw_rate",   {24'b0, rx_buf[0]}, 32'h0F);
    check("mbw_power_ctl", {24'b0, rx_buf[1]}, 32'h08);

    // Reset in the middle of a read frame.
    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    repeat (4) @(negedge clk);
    check("pre_rst_int", {31'b0, g_sensor_int}, 32'h1);
    spi_cs_n = 1'b0;
    half_bit();
    for (int i = 7; i >= 0; i--) send_bit(tx_buf[7][i] | (i == 7), rb, ob);
    for (int i = 0; i < 3; i++) send_bit(1'b0, rb, ob);
    check("pre_rst_oe", {31'b0, spi_sdat_oe}, 32'h1);
    reset_reset = 1'b1;
    #1;
    check("rst_mid_oe",  {31'b0, spi_sdat_oe},  32'h0);
    check("rst_mid_int", {31'b0, g_sensor_int}, 32'h0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b1;
    repeat (4) @(negedge clk);
    reset_reset = 1'b0;
    repeat (4) @(negedge clk);
    do_frame(8'hAC, 1, 0);
    check("rst_bw_rate",   {24'b0, rx_buf[0]}, 32'h0A);
    do_frame(8'hAD, 1, 0);
    check("rst_power_ctl", {24'b0, rx_buf[0]}, 32'h00);
    do_frame(8'hAE, 1, 0);
    check("rst_int_en",    {24'b0, rx_buf[0]}, 32'h00);
    do_frame(8'hB1, 1, 0);
    check("rst_data_fmt",  {24'b0, rx_buf[0]}, 32'h00);
    do_frame(8'hB2, 1, 0);
    check("rst_datax0",    {24'b0, rx_buf[0]}, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
